// File: rtl/scmp_bus_bridge_if.sv
// Bus bundle between the SC/MP core, the bridge and the memory/peripheral port.
// The bridge uses the slave view; the core/memory model side uses the master view.
interface scmp_bus_bridge_if;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_d_o;
  logic        cpu_ads_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic [7:0]  cpu_d_i;
  logic        cpu_hold;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        flag_h;
  logic        flag_d;
  logic        flag_i;
  logic        flag_r;
  logic        bus_err;
  logic        err_clr;

  modport slave (
    input  cpu_addr, cpu_d_o, cpu_ads_n, cpu_rd_n, cpu_wr_n, mem_ack, mem_rdata, err_clr,
    output cpu_d_i, cpu_hold, mem_addr, mem_wdata, mem_we, mem_req,
           flag_h, flag_d, flag_i, flag_r, bus_err
  );

  modport master (
    output cpu_addr, cpu_d_o, cpu_ads_n, cpu_rd_n, cpu_wr_n, mem_ack, mem_rdata, err_clr,
    input  cpu_d_i, cpu_hold, mem_addr, mem_wdata, mem_we, mem_req,
           flag_h, flag_d, flag_i, flag_r, bus_err
  );
endinterface

// File: rtl/scmp_bus_bridge.sv
// Demultiplexes the SC/MP bus into single req/ack transactions, stalling the
// core via cpu_hold until each one completes or times out.
module scmp_bus_bridge #(
  parameter int          TIMEOUT_CYCLES = 15,
  parameter logic [7:0]  RDATA_ON_ERR   = 8'hFF
) (
  input  logic           clk,
  input  logic           rst_n,
  scmp_bus_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, DONE} state_t;

  // Last REQ cycle index before abort; the counter starts at 0 on REQ entry.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        we_q;
  logic        req_q;
  logic        flag_h_q, flag_d_q, flag_i_q, flag_r_q;
  logic        err_q;
  logic        strobe_d;

  assign strobe_d = bus.cpu_ads_n && (!bus.cpu_rd_n || !bus.cpu_wr_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      flag_h_q <= 1'b0;
      flag_d_q <= 1'b0;
      flag_i_q <= 1'b0;
      flag_r_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // A clear is overridden by any error raised later in this block.
      if (bus.err_clr) err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!bus.cpu_ads_n) begin
            addr_q   <= {bus.cpu_d_o[3:0], bus.cpu_addr};
            flag_h_q <= bus.cpu_d_o[7];
            flag_d_q <= bus.cpu_d_o[6];
            flag_i_q <= bus.cpu_d_o[5];
            flag_r_q <= bus.cpu_d_o[4];
          end else if (!bus.cpu_rd_n) begin
            state_q <= RD_REQ;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            cnt_q   <= 8'd0;
            if (!bus.cpu_wr_n) err_q <= 1'b1;
          end else if (!bus.cpu_wr_n) begin
            state_q <= WR_REQ;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            wdata_q <= bus.cpu_d_o;
            cnt_q   <= 8'd0;
          end
        end

        RD_REQ, WR_REQ: begin
          if (bus.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (state_q == RD_REQ) rdata_q <= bus.mem_rdata;
          end else if (cnt_q == TO_LAST) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
            if (state_q == RD_REQ) rdata_q <= RDATA_ON_ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        DONE: begin
          // Wait for the core to drop its strobe so one bus cycle maps to one transaction.
          if (bus.cpu_rd_n && bus.cpu_wr_n) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_hold  = ((state_q == IDLE) && strobe_d) ||
                         (state_q == RD_REQ) || (state_q == WR_REQ);
  assign bus.cpu_d_i   = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_req   = req_q;
  assign bus.flag_h    = flag_h_q;
  assign bus.flag_d    = flag_d_q;
  assign bus.flag_i    = flag_i_q;
  assign bus.flag_r    = flag_r_q;
  assign bus.bus_err   = err_q;

endmodule

// File: tb/tb_scmp_bus_bridge.sv
// Directed bench for scmp_bus_bridge: reads, writes, timeout, protocol
// violation and reset in the middle of a transaction.
module tb_scmp_bus_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scmp_bus_bridge_if bus_if ();

  scmp_bus_bridge #(.TIMEOUT_CYCLES(15), .RDATA_ON_ERR(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_chk = 0;
  int n_bad = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    req_prev <= bus_if.mem_req;
    if (bus_if.mem_req && !req_prev) req_rises <= req_rises + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete bus cycle: ADS, strobe, REQ phase with ack in REQ cycle
  // ack_at (0-based, -1 = never), then strobe held for extra cycles in DONE.
  task automatic run_xfer(input bit wr, input bit both, input logic [7:0] stat,
                          input logic [11:0] a, input logic [7:0] wd, input int ack_at,
                          input logic [7:0] rdat, input int extra,
                          output int hold_n, output int req_n,
                          output logic we_s, output logic [7:0] wd_s);
    hold_n = 0; req_n = 0; we_s = 1'b0; wd_s = 8'h00;
    bus_if.cpu_ads_n = 1'b0; bus_if.cpu_d_o = stat; bus_if.cpu_addr = a;
    tick();
    bus_if.cpu_ads_n = 1'b1; bus_if.cpu_d_o = wd;
    if (wr || both) bus_if.cpu_wr_n = 1'b0;
    if (!wr || both) bus_if.cpu_rd_n = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus_if.mem_req) begin
        req_n++;
        if (req_n == 1) begin
          we_s = bus_if.mem_we;
          wd_s = bus_if.mem_wdata;
        end
      end
      if (bus_if.cpu_hold) hold_n++;
      else if (k > 0) break;
      bus_if.mem_ack   = bus_if.mem_req && ((req_n - 1) == ack_at);
      bus_if.mem_rdata = rdat;
      tick();
      bus_if.mem_ack = 1'b0;
    end
    for (int j = 0; j < extra; j++) begin
      tick();
      chk("done_hold", 32'(bus_if.cpu_hold), 32'd0);
      chk("done_req", 32'(bus_if.mem_req), 32'd0);
    end
    bus_if.cpu_rd_n = 1'b1; bus_if.cpu_wr_n = 1'b1;
    tick();
  endtask

  int hold_n, req_n, rises0;
  logic we_s;
  logic [7:0] wd_s;

  initial begin
    bus_if.cpu_addr = 12'h000; bus_if.cpu_d_o = 8'h00;
    bus_if.cpu_ads_n = 1'b1; bus_if.cpu_rd_n = 1'b1; bus_if.cpu_wr_n = 1'b1;
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 8'h00; bus_if.err_clr = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_req", 32'(bus_if.mem_req), 32'd0);
    chk("rst_hold", 32'(bus_if.cpu_hold), 32'd0);
    chk("rst_addr", 32'(bus_if.mem_addr), 32'h0);
    chk("rst_d_i", 32'(bus_if.cpu_d_i), 32'h0);
    chk("rst_err", 32'(bus_if.bus_err), 32'd0);
    chk("rst_flags", 32'({bus_if.flag_h, bus_if.flag_d, bus_if.flag_i, bus_if.flag_r}), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: read, ack in second REQ cycle
    rises0 = req_rises;
    run_xfer(1'b0, 1'b0, 8'h1A, 12'h345, 8'h00, 1, 8'h5C, 0, hold_n, req_n, we_s, wd_s);
    chk("t1_addr", 32'(bus_if.mem_addr), 32'hA345);
    chk("t1_flags", 32'({bus_if.flag_h, bus_if.flag_d, bus_if.flag_i, bus_if.flag_r}), 32'h1);
    chk("t1_hold", 32'(hold_n), 32'd3);
    chk("t1_reqcyc", 32'(req_n), 32'd2);
    chk("t1_we", 32'(we_s), 32'd0);
    chk("t1_d_i", 32'(bus_if.cpu_d_i), 32'h5C);
    chk("t1_rises", 32'(req_rises - rises0), 32'd1);

    // 2: write, ack in first REQ cycle
    run_xfer(1'b1, 1'b0, 8'h03, 12'hFFF, 8'h77, 0, 8'hEE, 0, hold_n, req_n, we_s, wd_s);
    chk("t2_addr", 32'(bus_if.mem_addr), 32'h3FFF);
    chk("t2_we", 32'(we_s), 32'd1);
    chk("t2_wdata", 32'(wd_s), 32'h77);
    chk("t2_hold", 32'(hold_n), 32'd2);
    chk("t2_d_i_kept", 32'(bus_if.cpu_d_i), 32'h5C);
    chk("t2_err", 32'(bus_if.bus_err), 32'd0);

    // 3: read timeout
    run_xfer(1'b0, 1'b0, 8'h10, 12'h123, 8'h00, -1, 8'h11, 0, hold_n, req_n, we_s, wd_s);
    chk("t3_reqcyc", 32'(req_n), 32'd15);
    chk("t3_hold", 32'(hold_n), 32'd16);
    chk("t3_d_i", 32'(bus_if.cpu_d_i), 32'hFF);
    chk("t3_err", 32'(bus_if.bus_err), 32'd1);
    bus_if.err_clr = 1'b1; tick(); bus_if.err_clr = 1'b0;
    chk("t3_errclr", 32'(bus_if.bus_err), 32'd0);

    // 4: ack coincident with the timeout cycle
    run_xfer(1'b0, 1'b0, 8'h10, 12'h456, 8'h00, 14, 8'h3C, 0, hold_n, req_n, we_s, wd_s);
    chk("t4_reqcyc", 32'(req_n), 32'd15);
    chk("t4_d_i", 32'(bus_if.cpu_d_i), 32'h3C);
    chk("t4_err", 32'(bus_if.bus_err), 32'd0);

    // 5: strobe held low for 6 cycles, immediate ack
    rises0 = req_rises;
    run_xfer(1'b0, 1'b0, 8'h50, 12'h0AA, 8'h00, 0, 8'hA5, 4, hold_n, req_n, we_s, wd_s);
    chk("t5_hold", 32'(hold_n), 32'd2);
    chk("t5_rises", 32'(req_rises - rises0), 32'd1);
    chk("t5_d_i", 32'(bus_if.cpu_d_i), 32'hA5);
    chk("t5_flags", 32'({bus_if.flag_h, bus_if.flag_d, bus_if.flag_i, bus_if.flag_r}), 32'h5);

    // both strobes low: read wins, bus_err set
    run_xfer(1'b0, 1'b1, 8'h80, 12'h010, 8'h00, 0, 8'h42, 0, hold_n, req_n, we_s, wd_s);
    chk("viol_we", 32'(we_s), 32'd0);
    chk("viol_d_i", 32'(bus_if.cpu_d_i), 32'h42);
    chk("viol_err", 32'(bus_if.bus_err), 32'd1);
    chk("viol_addr", 32'(bus_if.mem_addr), 32'h0010);
    chk("viol_flag_h", 32'(bus_if.flag_h), 32'd1);
    bus_if.err_clr = 1'b1; tick(); bus_if.err_clr = 1'b0;

    // stray ack in IDLE is ignored
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 8'h99; tick(); bus_if.mem_ack = 1'b0;
    chk("stray_err", 32'(bus_if.bus_err), 32'd0);
    chk("stray_req", 32'(bus_if.mem_req), 32'd0);
    chk("stray_d_i", 32'(bus_if.cpu_d_i), 32'h42);

    // 6: reset asserted while in WR_REQ
    bus_if.cpu_ads_n = 1'b0; bus_if.cpu_d_o = 8'h02; bus_if.cpu_addr = 12'h0AB;
    tick();
    bus_if.cpu_ads_n = 1'b1; bus_if.cpu_d_o = 8'h55; bus_if.cpu_wr_n = 1'b0;
    tick();
    chk("t6_req_pre", 32'(bus_if.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(bus_if.mem_req), 32'd0);
    chk("t6_we", 32'(bus_if.mem_we), 32'd0);
    chk("t6_addr", 32'(bus_if.mem_addr), 32'h0);
    chk("t6_wdata", 32'(bus_if.mem_wdata), 32'h0);
    chk("t6_d_i", 32'(bus_if.cpu_d_i), 32'h0);
    bus_if.cpu_wr_n = 1'b1;
    #1;
    chk("t6_hold", 32'(bus_if.cpu_hold), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    run_xfer(1'b1, 1'b0, 8'h04, 12'h123, 8'h99, 0, 8'h00, 0, hold_n, req_n, we_s, wd_s);
    chk("t6_post_addr", 32'(bus_if.mem_addr), 32'h4123);
    chk("t6_post_wdata", 32'(wd_s), 32'h99);
    chk("t6_post_hold", 32'(hold_n), 32'd2);
    chk("t6_post_err", 32'(bus_if.bus_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
